// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path and its round-robin arbiter.
// The packet-lock option is selected with the UART_ARB_LOCK_EN macro.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRIG,
        WAIT_BSY,
        WAIT_DONE
    } arb_state_t;

    localparam int UART_BYTE_W  = 8;
    localparam int SYSCLOCK_MHZ = 27;
    localparam int BAUD_MBPS    = 1;
    localparam int CLKPERFRM    = 270;

    // Index reached by stepping 'off' places from 'base' around a ring of 'n' slots.
    function automatic int unsigned rr_wrap(int unsigned base, int unsigned off, int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// req_last exists only when UART_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    import uart_pkg::*;

    logic [NREQ-1:0]             req_valid;
    logic [NREQ*UART_BYTE_W-1:0] req_data;
    logic [NREQ-1:0]             req_ready;
`ifdef UART_ARB_LOCK_EN
    logic [NREQ-1:0]             req_last;
`endif
    logic                        send_trig;
    logic [UART_BYTE_W-1:0]      send_data;
    logic                        tx_bsy;

`ifdef UART_ARB_LOCK_EN
    modport slave (
        input  req_valid, req_data, req_last, tx_bsy,
        output req_ready, send_trig, send_data
    );
    modport master (
        output req_valid, req_data, req_last, tx_bsy,
        input  req_ready, send_trig, send_data
    );
`else
    modport slave (
        input  req_valid, req_data, tx_bsy,
        output req_ready, send_trig, send_data
    );
    modport master (
        output req_valid, req_data, tx_bsy,
        input  req_ready, send_trig, send_data
    );
`endif

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDXW-1:0] gnt_idx,
    output logic            any
);

    // Scan from the farthest offset down so the nearest valid slot is written last.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[rr_wrap(32'(ptr), 32'(k), 32'(NREQ))]) begin
                any     = 1'b1;
                gnt_idx = IDXW'(rr_wrap(32'(ptr), 32'(k), 32'(NREQ)));
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign gnt_onehot[gi] = any && (gnt_idx == IDXW'(gi));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte producers, one frame at a time.
// Define UART_ARB_LOCK_EN to hold the grant on one requester until its req_last byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus,
    output logic [IDXW-1:0]  owner,
    output logic             busy
);

    arb_state_t             state_q, state_d;
    logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]        owner_q, owner_d;
    logic [UART_BYTE_W-1:0] send_data_q, send_data_d;

    logic [NREQ-1:0]        pick_req;
    logic [NREQ-1:0]        gnt_onehot;
    logic [IDXW-1:0]        gnt_idx;
    logic                   gnt_any;
    logic                   grant;
    logic [IDXW-1:0]        ptr_after_gnt;

`ifdef UART_ARB_LOCK_EN
    logic                   lock_act_q, lock_act_d;
    logic [IDXW-1:0]        lock_idx_q, lock_idx_d;
    logic [NREQ-1:0]        lock_mask;

    // While a packet is open only its owner reaches the picker.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lock_mask
        assign lock_mask[gi] = !lock_act_q || (lock_idx_q == IDXW'(gi));
    end
    assign pick_req = bus.req_valid & lock_mask;
`else
    assign pick_req = bus.req_valid;
`endif

    uart_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req        (pick_req),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    assign grant         = (state_q == IDLE) && !bus.tx_bsy && gnt_any;
    assign ptr_after_gnt = (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        send_data_d   = send_data_q;
        bus.req_ready = '0;
`ifdef UART_ARB_LOCK_EN
        lock_act_d    = lock_act_q;
        lock_idx_d    = lock_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant) begin
                    bus.req_ready = gnt_onehot;
                    send_data_d   = bus.req_data[UART_BYTE_W*gnt_idx +: UART_BYTE_W];
                    owner_d       = gnt_idx;
                    state_d       = TRIG;
`ifdef UART_ARB_LOCK_EN
                    lock_idx_d    = gnt_idx;
                    if (bus.req_last[gnt_idx]) begin
                        lock_act_d = 1'b0;
                        rr_ptr_d   = ptr_after_gnt;
                    end else begin
                        lock_act_d = 1'b1;
                    end
`else
                    rr_ptr_d      = ptr_after_gnt;
`endif
                end
            end
            TRIG:      state_d = WAIT_BSY;
            // Without a timeout, a transmitter that never asserts busy parks us here.
            WAIT_BSY:  if (bus.tx_bsy)  state_d = WAIT_DONE;
            WAIT_DONE: if (!bus.tx_bsy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            send_data_q <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_act_q  <= 1'b0;
            lock_idx_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            send_data_q <= send_data_d;
`ifdef UART_ARB_LOCK_EN
            lock_act_q  <= lock_act_d;
            lock_idx_q  <= lock_idx_d;
`endif
        end
    end

    assign bus.send_trig = (state_q == TRIG);
    assign bus.send_data = send_data_q;
    assign owner         = owner_q;
    assign busy          = (state_q != IDLE);

endmodule
